// File: rtl/demux_pipeline.sv
// demux_pipeline: pipelined 1-to-OUTPUT_COUNT demultiplexer.
// A word travels through an optional input delay line and then a tree of
// registered fan-out units; each tree stage decodes one group of sel bits,
// most significant group first. The tree radix is chosen so that routing
// takes exactly LATENCY cycles. With LATENCY = 0 the routing is combinational
// and only the per-lane holding registers remain.
module demux_pipeline #(
    parameter int WIDTH        = 1,
    parameter int OUTPUT_COUNT = 2,
    parameter int LATENCY      = 0,
    parameter bit HOLD         = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    input  logic [$clog2(OUTPUT_COUNT):0]     sel,
    input  logic [WIDTH-1:0]                  in,
    output logic [WIDTH*OUTPUT_COUNT-1:0]     out,
    output logic [OUTPUT_COUNT-1:0]           out_valid,
    output logic                              sel_err
);

    // base**exp, saturated at cap so the arithmetic never overflows
    function automatic int pow_cap(input int base, input int exp, input int cap);
        int r;
        r = 1;
        for (int i = 0; i < exp; i++)
            if (r < cap) r = r * base;
        return (r > cap) ? cap : r;
    endfunction

    // smallest power of two (>= 2) whose LATENCY-th power covers all lanes
    function automatic int calc_unit(input int lat, input int cnt);
        int u;
        u = 2;
        if (lat > 0)
            for (int i = 0; i < 31; i++)
                if (pow_cap(u, lat, cnt) < cnt) u = u * 2;
        return u;
    endfunction

    // number of tree stages needed to reach every lane
    function automatic int calc_depth(input int unit, input int cnt);
        int d;
        d = 1;
        for (int i = 0; i < 31; i++)
            if (pow_cap(unit, d, cnt) < cnt) d = d + 1;
        return d;
    endfunction

    // nodes built at tree level s (subtrees lying wholly beyond the last lane are pruned)
    function automatic int level_nodes(input int unit, input int depth, input int cnt, input int s);
        int span;
        span = pow_cap(unit, depth - 1 - s, cnt);
        return (cnt + span - 1) / span;
    endfunction

    // flat index of the first node of level s
    function automatic int node_off(input int unit, input int depth, input int cnt, input int s);
        int r;
        r = 0;
        for (int l = 0; l < s; l++) r = r + level_nodes(unit, depth, cnt, l);
        return r;
    endfunction

    // flat bit offset of the first remaining-sel field of level s
    function automatic int sel_off(input int unit, input int depth, input int cnt, input int sw, input int s);
        int r;
        r = 0;
        for (int l = 0; l < s; l++) r = r + level_nodes(unit, depth, cnt, l) * sw * (depth - 1 - l);
        return r;
    endfunction

    localparam int SELW      = $clog2(OUTPUT_COUNT) + 1;
    localparam int UNIT      = calc_unit(LATENCY, OUTPUT_COUNT);
    localparam int SEL_WIDTH = $clog2(UNIT);
    localparam int DEPTH     = (LATENCY > 0) ? calc_depth(UNIT, OUTPUT_COUNT) : 0;
    localparam int PAD       = LATENCY - DEPTH;

    localparam logic [SELW-1:0] LANE_LIMIT = SELW'(OUTPUT_COUNT);

    // Range check happens once at the input; the tree only ever sees in-range words.
    logic in_ok;
    logic in_err;
    assign in_ok  = in_valid && (sel <  LANE_LIMIT);
    assign in_err = in_valid && (sel >= LANE_LIMIT);

    if (LATENCY == 0) begin : gen_comb

        logic [OUTPUT_COUNT-1:0]       hit;
        logic [WIDTH*OUTPUT_COUNT-1:0] held;

        // Combinational lane decode and output mux over the held lane values
        // NOTE: every output gets a default at the top of always_comb so no path leaves it unassigned (no latch).
        always_comb begin
            hit = '0;
            for (int k = 0; k < OUTPUT_COUNT; k++)
                hit[k] = in_ok && (sel == SELW'(k));
            out_valid = hit;
            sel_err   = in_err;
            out       = held;
            for (int k = 0; k < OUTPUT_COUNT; k++) begin
                if (hit[k])
                    out[WIDTH*k +: WIDTH] = in;
                else if (!HOLD && (|hit))
                    out[WIDTH*k +: WIDTH] = '0;
            end
        end

        // Capture the lane values shown in a delivery cycle so they persist afterwards
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                held <= '0;
            else if (|hit)
                held <= out;
        end

    end else begin : gen_tree

        localparam int TREE_SEL = SEL_WIDTH * DEPTH;
        localparam int NODES    = node_off(UNIT, DEPTH, OUTPUT_COUNT, DEPTH);
        localparam int SEL_BITS = sel_off(UNIT, DEPTH, OUTPUT_COUNT, SEL_WIDTH, DEPTH);
        localparam int SB       = (SEL_BITS > 0) ? SEL_BITS : 1;
        localparam int LEAF_OFF = node_off(UNIT, DEPTH, OUTPUT_COUNT, DEPTH - 1);

        logic                      root_v;
        logic [WIDTH-1:0]          root_d;
        logic [TREE_SEL-1:0]       root_s;

        logic [NODES-1:0]            node_v;
        logic [NODES-1:0][WIDTH-1:0] node_d;
        logic [SB-1:0]               node_s;
        logic [LATENCY-1:0]          err_r;

        // Out-of-range flag travels alongside the tree with the full latency
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                err_r <= '0;
            end else begin
                err_r[0] <= in_err;
                for (int p = 1; p < LATENCY; p++)
                    err_r[p] <= err_r[p-1];
            end
        end

        if (PAD == 0) begin : gen_nopad
            assign root_v = in_ok;
            assign root_d = in;
            assign root_s = TREE_SEL'(sel);
        end else begin : gen_pad
            logic [PAD-1:0]                v_r;
            logic [PAD-1:0][WIDTH-1:0]     d_r;
            logic [PAD-1:0][TREE_SEL-1:0]  s_r;

            // Plain delay stages that make up the latency the tree does not use
            // NOTE: data registers are reset along with the valid bits so out reads 0 straight out of reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_r <= '0;
                    d_r <= '0;
                    s_r <= '0;
                end else begin
                    v_r[0] <= in_ok;
                    if (in_ok) begin
                        d_r[0] <= in;
                        s_r[0] <= TREE_SEL'(sel);
                    end
                    for (int p = 1; p < PAD; p++) begin
                        v_r[p] <= v_r[p-1];
                        if (v_r[p-1]) begin
                            d_r[p] <= d_r[p-1];
                            s_r[p] <= s_r[p-1];
                        end
                    end
                end
            end

            assign root_v = v_r[PAD-1];
            assign root_d = d_r[PAD-1];
            assign root_s = s_r[PAD-1];
        end

        if (SEL_BITS == 0) begin : gen_no_rem
            assign node_s = '0;
        end

        for (genvar s = 0; s < DEPTH; s++) begin : gen_level
            localparam int N    = level_nodes(UNIT, DEPTH, OUTPUT_COUNT, s);
            localparam int OFF  = node_off(UNIT, DEPTH, OUTPUT_COUNT, s);
            localparam int SOFF = sel_off(UNIT, DEPTH, OUTPUT_COUNT, SEL_WIDTH, s);
            localparam int REM  = SEL_WIDTH * (DEPTH - 1 - s);
            localparam int PREM = REM + SEL_WIDTH;
            localparam bit LAST = (s == DEPTH - 1);

            logic [N-1:0]            par_v;
            logic [N-1:0][WIDTH-1:0] par_d;
            logic [N-1:0][PREM-1:0]  par_s;
            logic [N-1:0]            hit;
            logic                    zero_others;
            logic [N-1:0]            v_r;
            logic [N-1:0][WIDTH-1:0] d_r;

            for (genvar j = 0; j < N; j++) begin : gen_par
                if (s == 0) begin : gen_from_root
                    assign par_v[j] = root_v;
                    assign par_d[j] = root_d;
                    assign par_s[j] = root_s;
                end else begin : gen_from_level
                    localparam int PIDX  = node_off(UNIT, DEPTH, OUTPUT_COUNT, s - 1) + j / UNIT;
                    localparam int PSOFF = sel_off(UNIT, DEPTH, OUTPUT_COUNT, SEL_WIDTH, s - 1)
                                           + (j / UNIT) * PREM;
                    assign par_v[j] = node_v[PIDX];
                    assign par_d[j] = node_d[PIDX];
                    assign par_s[j] = node_s[PSOFF +: PREM];
                end
            end

            // Branch decode: a child fires when its parent is valid and the top sel group names it
            always_comb begin
                hit = '0;
                for (int j = 0; j < N; j++)
                    hit[j] = par_v[j] && (par_s[j][PREM-1 -: SEL_WIDTH] == SEL_WIDTH'(j % UNIT));
            end

            // At the leaves with HOLD = 0, a delivery anywhere clears every other lane
            assign zero_others = !HOLD && LAST && (|par_v);

            // Fan-out registers: only the selected branch loads, the rest keep their data
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_r <= '0;
                    d_r <= '0;
                end else begin
                    v_r <= hit;
                    for (int j = 0; j < N; j++) begin
                        if (hit[j])
                            d_r[j] <= par_d[j];
                        else if (zero_others)
                            d_r[j] <= '0;
                    end
                end
            end

            assign node_v[OFF +: N] = v_r;
            assign node_d[OFF +: N] = d_r;

            if (REM > 0) begin : gen_rem
                logic [N-1:0][REM-1:0] s_r;

                // Forward the still-undecoded sel bits down the selected branch
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        s_r <= '0;
                    end else begin
                        for (int j = 0; j < N; j++)
                            if (hit[j]) s_r[j] <= par_s[j][REM-1:0];
                    end
                end

                assign node_s[SOFF +: N*REM] = s_r;
            end
        end

        assign out_valid = node_v[LEAF_OFF +: OUTPUT_COUNT];
        assign out       = node_d[LEAF_OFF +: OUTPUT_COUNT];
        assign sel_err   = err_r[LATENCY-1];

    end

endmodule

// File: tb/tb_demux_pipeline.sv
// Bench for demux_pipeline: six configurations share one clock and reset.
// Each driven word pushes its expected delivery (cycle, lane, data, error)
// into a per-instance queue; a negedge monitor pops due entries, updates a
// lane model and compares out_valid, sel_err and every lane each cycle.
module tb_demux_pipeline;

    localparam int NI = 6;
    localparam int LAT_T  [NI] = '{1, 2, 4, 1, 0, 3};
    localparam int OC_T   [NI] = '{4, 5, 16, 4, 3, 4};
    localparam int W_T    [NI] = '{8, 8, 4, 8, 8, 8};
    localparam int HOLD_T [NI] = '{1, 1, 1, 0, 1, 1};

    typedef struct {
        int         due;
        int         lane;
        logic [7:0] data;
        bit         err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv   [NI];
    logic [4:0] isel [NI];
    logic [7:0] idat [NI];

    logic [31:0] out0; logic [3:0]  ov0; logic e0;
    logic [39:0] out1; logic [4:0]  ov1; logic e1;
    logic [63:0] out2; logic [15:0] ov2; logic e2;
    logic [31:0] out3; logic [3:0]  ov3; logic e3;
    logic [23:0] out4; logic [2:0]  ov4; logic e4;
    logic [31:0] out5; logic [3:0]  ov5; logic e5;

    logic [127:0] act_l [NI];
    logic [15:0]  act_v [NI];
    logic         act_e [NI];

    exp_t       sb     [NI][$];
    logic [7:0] m_lane [NI][16];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    exp_t         mon_e;
    logic [15:0]  mon_v;
    logic         mon_err;
    logic [127:0] mon_l;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    demux_pipeline #(.WIDTH(8), .OUTPUT_COUNT(4), .LATENCY(1), .HOLD(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .sel(isel[0][2:0]), .in(idat[0]),
        .out(out0), .out_valid(ov0), .sel_err(e0));
    demux_pipeline #(.WIDTH(8), .OUTPUT_COUNT(5), .LATENCY(2), .HOLD(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .sel(isel[1][3:0]), .in(idat[1]),
        .out(out1), .out_valid(ov1), .sel_err(e1));
    demux_pipeline #(.WIDTH(4), .OUTPUT_COUNT(16), .LATENCY(4), .HOLD(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .sel(isel[2]), .in(idat[2][3:0]),
        .out(out2), .out_valid(ov2), .sel_err(e2));
    demux_pipeline #(.WIDTH(8), .OUTPUT_COUNT(4), .LATENCY(1), .HOLD(0)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .sel(isel[3][2:0]), .in(idat[3]),
        .out(out3), .out_valid(ov3), .sel_err(e3));
    demux_pipeline #(.WIDTH(8), .OUTPUT_COUNT(3), .LATENCY(0), .HOLD(1)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .sel(isel[4][2:0]), .in(idat[4]),
        .out(out4), .out_valid(ov4), .sel_err(e4));
    demux_pipeline #(.WIDTH(8), .OUTPUT_COUNT(4), .LATENCY(3), .HOLD(1)) u5 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[5]), .sel(isel[5][2:0]), .in(idat[5]),
        .out(out5), .out_valid(ov5), .sel_err(e5));

    // Normalise every instance to 16 lanes of 8 bits
    always_comb begin
        act_l[0] = 128'(out0); act_v[0] = 16'(ov0); act_e[0] = e0;
        act_l[1] = 128'(out1); act_v[1] = 16'(ov1); act_e[1] = e1;
        act_l[2] = '0;         act_v[2] = ov2;      act_e[2] = e2;
        for (int k = 0; k < 16; k++) act_l[2][8*k +: 8] = {4'b0, out2[4*k +: 4]};
        act_l[3] = 128'(out3); act_v[3] = 16'(ov3); act_e[3] = e3;
        act_l[4] = 128'(out4); act_v[4] = 16'(ov4); act_e[4] = e4;
        act_l[5] = 128'(out5); act_v[5] = 16'(ov5); act_e[5] = e5;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: pop due entries, update the lane model, compare everything
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            mon_v   = '0;
            mon_err = 1'b0;
            if (sb[i].size() > 0 && sb[i][0].due == cyc) begin
                mon_e = sb[i].pop_front();
                if (mon_e.err) begin
                    mon_err = 1'b1;
                end else begin
                    mon_v[mon_e.lane] = 1'b1;
                    if (HOLD_T[i] == 0)
                        for (int k = 0; k < 16; k++) m_lane[i][k] = 8'h00;
                    m_lane[i][mon_e.lane] = mon_e.data;
                end
            end
            for (int k = 0; k < 16; k++) mon_l[8*k +: 8] = m_lane[i][k];
            check($sformatf("u%0d out_valid c%0d", i, cyc), 128'(act_v[i]), 128'(mon_v));
            check($sformatf("u%0d sel_err c%0d", i, cyc), 128'(act_e[i]), 128'(mon_err));
            check($sformatf("u%0d lanes c%0d", i, cyc), act_l[i], mon_l);
        end
    end

    task automatic clear_model();
        for (int i = 0; i < NI; i++) begin
            sb[i].delete();
            for (int k = 0; k < 16; k++) m_lane[i][k] = 8'h00;
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            iv[i]   = 1'b0;
            isel[i] = 5'($urandom);
            idat[i] = 8'($urandom);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            idle_all();
        end
    endtask

    task automatic send(input int i, input int lane, input logic [7:0] d);
        exp_t e;
        @(posedge clk); #1;
        idle_all();
        iv[i]   = 1'b1;
        isel[i] = 5'(lane);
        idat[i] = d;
        e.due  = cyc + LAT_T[i];
        e.lane = lane;
        e.data = (W_T[i] == 4) ? {4'b0, d[3:0]} : d;
        e.err  = (lane >= OC_T[i]);
        sb[i].push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        idle_all();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // single word, one-cycle latency
        send(0, 2, 8'hA5);
        idle(2);

        // back-to-back words to every lane, then out-of-range selects
        send(1, 4, 8'h11); send(1, 3, 8'h12); send(1, 2, 8'h13);
        send(1, 1, 8'h14); send(1, 0, 8'h15);
        idle(3);
        send(1, 5, 8'h66); send(1, 7, 8'h77);
        idle(3);
        send(0, 7, 8'h99); send(2, 31, 8'h0E);
        idle(5);

        // reset while a word is in flight
        send(2, 9, 8'h03);
        idle(1);
        @(posedge clk); #2;
        idle_all();
        rst_n = 1'b0;
        clear_model();
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d async out_valid", i), 128'(act_v[i]), 128'(0));
            check($sformatf("u%0d async sel_err", i), 128'(act_e[i]), 128'(0));
            check($sformatf("u%0d async lanes", i), act_l[i], 128'(0));
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(2, 9, 8'h07);
        idle(6);

        // HOLD = 0 versus HOLD = 1
        send(3, 0, 8'hFF); send(3, 1, 8'h0C);
        idle(2);
        send(0, 0, 8'hFF); send(0, 1, 8'h0C);
        idle(2);

        // combinational configuration
        send(4, 1, 8'h5A);
        idle(1);
        send(4, 3, 8'h33); send(4, 0, 8'hC3); send(4, 2, 8'h81);
        idle(1);

        // padded tree: same lane back to back, then an error
        send(5, 3, 8'hAA); send(5, 3, 8'hBB); send(5, 0, 8'h01); send(5, 4, 8'h44);
        idle(4);

        // random traffic across all instances
        for (int n = 0; n < 80; n++) begin
            int i;
            i = $urandom_range(0, NI - 1);
            if ($urandom_range(0, 5) == 0)
                idle(1);
            else
                send(i, $urandom_range(0, OC_T[i] + 2), 8'($urandom));
        end
        idle(6);

        for (int i = 0; i < NI; i++)
            check($sformatf("u%0d scoreboard drained", i), 128'(sb[i].size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
